// File: rtl/alu_pkg.sv
// Shared constants and FSM state encoding for the ALU scheduler and the ALU datapath.
package alu_pkg;
    localparam int OP_W  = 4;
    localparam int SEL_W = 3;
    localparam int RES_W = 8;
    localparam int ID_W  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU datapath: two operands and a 3-bit select give an 8-bit result.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [SEL_W-1:0] s,
    output logic [RES_W-1:0] y
);
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = {4'b0000, a};
    assign b_ext = {4'b0000, b};

    // Subtraction wraps in 8 bits, so a < b yields the two's-complement result.
    always_comb begin
        y = '0;
        case (s)
            3'b000:  y = a_ext + b_ext;
            3'b001:  y = a_ext - b_ext;
            3'b010:  y = a_ext & b_ext;
            3'b011:  y = a_ext | b_ext;
            3'b100:  y = a_ext ^ b_ext;
            3'b101:  y = a_ext * b_ext;
            3'b110:  y = {4'b0000, ~a};
            default: y = {a, b};
        endcase
    end
endmodule

// File: rtl/alu_sched_rr.sv
// Two-way round-robin picker: a lone valid wins outright, a tie goes to the requester not granted last.
module alu_sched_rr
    import alu_pkg::*;
(
    input  logic            valid0,
    input  logic            valid1,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] winner,
    output logic            grant
);
    assign grant  = valid0 | valid1;
    assign winner = (valid0 && valid1) ? ~last : (valid1 ? 1'b1 : 1'b0);
endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Per-requester grant counters exist only when ALU_SCHED_STATS_EN is defined; otherwise they read 0.
module alu_sched
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic [SEL_W-1:0]  req0_s,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    input  logic [SEL_W-1:0]  req1_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [RES_W-1:0]  rsp_y,
    output logic              busy,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);
    state_t            state_reg, state_next;
    logic [OP_W-1:0]   op_a_reg, op_b_reg;
    logic [SEL_W-1:0]  op_s_reg;
    logic [ID_W-1:0]   op_id_reg;
    logic [ID_W-1:0]   last_reg;
    logic [RES_W-1:0]  rsp_y_reg;
    logic [RES_W-1:0]  alu_y;
    logic [ID_W-1:0]   pick_id;
    logic              pick_grant;
    logic              accept;

    alu_sched_rr u_rr (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last   (last_reg),
        .winner (pick_id),
        .grant  (pick_grant)
    );

    // The ALU only ever sees the operand register, never the live request ports.
    alu u_alu (
        .a (op_a_reg),
        .b (op_b_reg),
        .s (op_s_reg),
        .y (alu_y)
    );

    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_grant && !rst) begin
                    req0_ready = ~pick_id[0];
                    req1_ready = pick_id[0];
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            op_s_reg  <= '0;
            op_id_reg <= '0;
            last_reg  <= 1'b1;
            rsp_y_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_a_reg  <= pick_id[0] ? req1_a : req0_a;
                op_b_reg  <= pick_id[0] ? req1_b : req0_b;
                op_s_reg  <= pick_id[0] ? req1_s : req0_s;
                op_id_reg <= pick_id;
                last_reg  <= pick_id;
            end
            if (state_reg == ST_EXEC) rsp_y_reg <= alu_y;
        end
    end

    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = op_id_reg;
    assign rsp_y     = rsp_y_reg;
    assign busy      = (state_reg != ST_IDLE);

`ifdef ALU_SCHED_STATS_EN
    logic [1:0]       acc_vec;
    logic [CNT_W-1:0] cnt_reg [2];

    assign acc_vec = {accept & pick_id[0], accept & ~pick_id[0]};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        // Saturate at all-ones rather than wrapping.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg[gi] <= '0;
            end else if (acc_vec[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    end

    assign grant_cnt0 = cnt_reg[0];
    assign grant_cnt1 = cnt_reg[1];
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched; counter expectations follow ALU_SCHED_STATS_EN.
module tb_alu_sched;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]       req0_s = '0, req1_s = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [0:0]       rsp_id;
    logic [7:0]       rsp_y;
    logic             busy;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef ALU_SCHED_STATS_EN
    localparam logic [CNT_W-1:0] EXP_SAT = 2'd3;
`else
    localparam logic [CNT_W-1:0] EXP_SAT = 2'd0;
`endif

    alu_sched #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_s     (req0_s),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_s     (req1_s),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .busy       (busy),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset cycle: both valids high, readies must still be 0.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_cnt0", grant_cnt0, 0);
        check("rst_cnt1", grant_cnt1, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single request: req0 9+3 = 12.
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd3; req0_s = 3'b000;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("single_exec_busy", busy, 1);
        check("single_exec_valid", rsp_valid, 0);
        tick();
        check("single_resp_valid", rsp_valid, 1);
        check("single_resp_busy", busy, 1);
        check("single_resp_id", rsp_id, 0);
        check("single_resp_y", rsp_y, 8'h0C);
        tick();
        check("single_idle_busy", busy, 0);
        check("single_idle_valid", rsp_valid, 0);

        // Simultaneous requests after reset: req0 9-11 = FE first, then req1 13|11 = 0F.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd9;  req0_b = 4'd11; req0_s = 3'b001;
        req1_valid = 1'b1; req1_a = 4'd13; req1_b = 4'd11; req1_s = 3'b011;
        #1;
        check("sim_ready0", req0_ready, 1);
        check("sim_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("sim_exec_ready1", req1_ready, 0);
        tick();
        check("sim_resp0_id", rsp_id, 0);
        check("sim_resp0_y", rsp_y, 8'hFE);
        check("sim_resp0_ready1", req1_ready, 0);
        tick();
        check("sim_idle_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("sim_resp1_valid", rsp_valid, 1);
        check("sim_resp1_id", rsp_id, 1);
        check("sim_resp1_y", rsp_y, 8'h0F);
        tick();

        // Fairness: both held valid for six operations; req0 2*3 = 6, req1 7^5 = 2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_s = 3'b101;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd5; req1_s = 3'b100;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("fair%0d_ready0", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            check($sformatf("fair%0d_ready1", i), req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            tick();
            check($sformatf("fair%0d_id", i), rsp_id, i % 2);
            check($sformatf("fair%0d_y", i), rsp_y, (i % 2 == 0) ? 8'h06 : 8'h02);
            tick();
        end
        check("fair_cnt0", grant_cnt0, EXP_SAT);
        check("fair_cnt1", grant_cnt1, EXP_SAT);

        // Backpressure: req0 15*15 = E1 held in RESP for 5 cycles; req1 (1+2 = 3) waits.
        req0_a = 4'd15; req0_b = 4'd15; req0_s = 3'b101;
        req1_a = 4'd1;  req1_b = 4'd2;  req1_s = 3'b000;
        rsp_ready = 1'b0;
        #1;
        check("bp_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d_valid", i), rsp_valid, 1);
            check($sformatf("bp%0d_y", i), rsp_y, 8'hE1);
            check($sformatf("bp%0d_id", i), rsp_id, 0);
            check($sformatf("bp%0d_ready1", i), req1_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready1", req1_ready, 0);
        check("bp_release_valid", rsp_valid, 1);
        tick();
        check("bp_idle_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check("bp_accept_busy", busy, 1);
        tick();
        check("bp_resp1_id", rsp_id, 1);
        check("bp_resp1_y", rsp_y, 8'h03);
        tick();

        // Mid-operation reset: req1 (last granted) reset during EXEC; then req0 wins the tie.
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4; req1_s = 3'b000;
        #1;
        check("mid_ready1", req1_ready, 1);
        tick();
        check("mid_exec_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_y", rsp_y, 0);
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_s = 3'b000;
        #1;
        check("mid_after_ready0", req0_ready, 1);
        check("mid_after_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("mid_resp_id", rsp_id, 0);
        check("mid_resp_y", rsp_y, 8'h02);
        tick();

        // Saturation: five req1 acceptances with 2-bit counters.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd5; req1_s = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("sat%0d_ready1", i), req1_ready, 1);
            tick();
            tick();
            check($sformatf("sat%0d_y", i), rsp_y, 8'h01);
            tick();
        end
        req1_valid = 1'b0;
        check("sat_cnt1", grant_cnt1, EXP_SAT);
        check("sat_cnt0", grant_cnt0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
